// File: rtl/cache_refill_engine_if.sv
// Miss-request, memory-beat and fill-return bundle of the refill engine.
// slave = engine side, master = controller/memory side.
interface cache_refill_engine_if #(
  parameter int WAYS            = 4,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int OFFSET_BITS     = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_SIZE_BYTES = 64
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int ADDR_W = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int LINE_W = LINE_SIZE_BYTES * 8;

  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_W-1:0]     miss_addr;
  logic [WAYS-1:0]       set_valid;
  logic [WAYS-1:0]       set_dirty;
  logic [WAYS-1:0]       set_lru;
  logic [WAY_W-1:0]      victim_way;
  logic [TAG_BITS-1:0]   victim_tag;
  logic [LINE_W-1:0]     victim_line;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fill_valid;
  logic [WAY_W-1:0]      fill_way;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [LINE_W-1:0]     fill_line;
  logic                  busy;

  modport slave (
    input  miss_valid, miss_addr, set_valid, set_dirty, set_lru,
    input  victim_tag, victim_line, mem_ack, mem_rdata,
    output miss_ready, victim_way, mem_req, mem_we, mem_addr, mem_wdata,
    output fill_valid, fill_way, fill_index, fill_tag, fill_line, busy
  );

  modport master (
    output miss_valid, miss_addr, set_valid, set_dirty, set_lru,
    output victim_tag, victim_line, mem_ack, mem_rdata,
    input  miss_ready, victim_way, mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_valid, fill_way, fill_index, fill_tag, fill_line, busy
  );
endinterface

// File: rtl/cache_refill_engine.sv
// Cache miss refill: victim select, dirty write-back, then
// critical-word-first line fetch returned as a one-cycle fill pulse.
module cache_refill_engine #(
  parameter int WAYS            = 4,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int OFFSET_BITS     = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_SIZE_BYTES = 64
) (
  input logic                  clk,
  input logic                  rst,
  cache_refill_engine_if.slave bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int ADDR_W = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int LINE_W = LINE_SIZE_BYTES * 8;
  localparam int WORDS  = LINE_W / DATA_WIDTH;
  localparam int BEAT_W = $clog2(WORDS);
  localparam int CNT_W  = BEAT_W + 1;
  localparam int LSB_W  = OFFSET_BITS - BEAT_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WB, S_FILL, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [BEAT_W-1:0]     crit_q, crit_d;
  logic [WAYS-1:0]       valid_q, valid_d;
  logic [WAYS-1:0]       dirty_q, dirty_d;
  logic [WAYS-1:0]       lru_q, lru_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [TAG_BITS-1:0]   wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0]     wb_line_q, wb_line_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      done_q, done_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [WAY_W-1:0]      fill_way_q, fill_way_d;
  logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
  logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;
  logic [LINE_W-1:0]     fill_line_q, fill_line_d;

  logic [WAY_W-1:0]  sel;
  logic              need_wb;
  logic              beat_done;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [LINE_W-1:0] line_upd;
  logic              unused;

  assign unused = ^bus.miss_addr[1:0];

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [TAG_BITS-1:0]   t,
    input logic [INDEX_BITS-1:0] i,
    input logic [BEAT_W-1:0]     b
  );
    return {t, i, b, {LSB_W{1'b0}}};
  endfunction

  // invalid ways beat not-recently-used ways; way 0 if neither exists
  always_comb begin
    sel = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (!lru_q[i]) sel = WAY_W'(i);
    for (int i = WAYS-1; i >= 0; i--)
      if (!valid_q[i]) sel = WAY_W'(i);
  end

  assign need_wb   = valid_q[sel] & dirty_q[sel];
  assign beat_done = mem_req_q & bus.mem_ack;
  assign last_beat = done_q == CNT_W'(WORDS-1);
  assign beat_nxt  = beat_q + 1'b1;

  always_comb begin
    line_upd = line_q;
    line_upd[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    crit_d       = crit_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    victim_d     = victim_q;
    wb_tag_d     = wb_tag_q;
    wb_line_d    = wb_line_q;
    beat_d       = beat_q;
    done_d       = done_q;
    line_d       = line_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_valid_d = 1'b0;
    fill_way_d   = fill_way_q;
    fill_index_d = fill_index_q;
    fill_tag_d   = fill_tag_q;
    fill_line_d  = fill_line_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) begin
          tag_d   = bus.miss_addr[ADDR_W-1 -: TAG_BITS];
          idx_d   = bus.miss_addr[OFFSET_BITS +: INDEX_BITS];
          crit_d  = bus.miss_addr[LSB_W +: BEAT_W];
          valid_d = bus.set_valid;
          dirty_d = bus.set_dirty;
          lru_d   = bus.set_lru;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        victim_d  = sel;
        done_d    = '0;
        mem_req_d = 1'b1;
        if (need_wb) begin
          // victim_way has been on the port all of this cycle
          wb_tag_d    = bus.victim_tag;
          wb_line_d   = bus.victim_line;
          beat_d      = '0;
          mem_we_d    = 1'b1;
          mem_addr_d  = beat_addr(bus.victim_tag, idx_q, '0);
          mem_wdata_d = bus.victim_line[DATA_WIDTH-1:0];
          state_d     = S_WB;
        end else begin
          beat_d     = crit_q;
          mem_we_d   = 1'b0;
          mem_addr_d = beat_addr(tag_q, idx_q, crit_q);
          state_d    = S_FILL;
        end
      end
      S_WB: begin
        if (beat_done) begin
          done_d = done_q + 1'b1;
          beat_d = beat_nxt;
          if (last_beat) begin
            done_d     = '0;
            beat_d     = crit_q;
            mem_we_d   = 1'b0;
            mem_addr_d = beat_addr(tag_q, idx_q, crit_q);
            state_d    = S_FILL;
          end else begin
            mem_addr_d  = beat_addr(wb_tag_q, idx_q, beat_nxt);
            mem_wdata_d =
              wb_line_q[int'(beat_nxt)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      S_FILL: begin
        if (beat_done) begin
          line_d = line_upd;
          done_d = done_q + 1'b1;
          beat_d = beat_nxt;
          if (last_beat) begin
            mem_req_d    = 1'b0;
            fill_valid_d = 1'b1;
            fill_way_d   = victim_q;
            fill_index_d = idx_q;
            fill_tag_d   = tag_q;
            fill_line_d  = line_upd;
            state_d      = S_DONE;
          end else begin
            mem_addr_d = beat_addr(tag_q, idx_q, beat_nxt);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      crit_q       <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      victim_q     <= '0;
      wb_tag_q     <= '0;
      wb_line_q    <= '0;
      beat_q       <= '0;
      done_q       <= '0;
      line_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      crit_q       <= crit_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
      victim_q     <= victim_d;
      wb_tag_q     <= wb_tag_d;
      wb_line_q    <= wb_line_d;
      beat_q       <= beat_d;
      done_q       <= done_d;
      line_q       <= line_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_valid_q <= fill_valid_d;
      fill_way_q   <= fill_way_d;
      fill_index_q <= fill_index_d;
      fill_tag_q   <= fill_tag_d;
      fill_line_q  <= fill_line_d;
    end
  end

  assign bus.miss_ready = state_q == S_IDLE;
  assign bus.busy       = state_q != S_IDLE;
  assign bus.victim_way = (state_q == S_SELECT) ? sel : victim_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_way   = fill_way_q;
  assign bus.fill_index = fill_index_q;
  assign bus.fill_tag   = fill_tag_q;
  assign bus.fill_line  = fill_line_q;
endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine with a
// wait-state-programmable memory responder.
module tb_cache_refill_engine;
  logic clk;
  logic rst;

  cache_refill_engine_if bus ();

  cache_refill_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int delay    = 0;
  logic stray_ack = 1'b0;

  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_we[$];
  int          stalls;
  int          stab_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [511:0] exp_line(
    input logic [17:0] t, input logic [7:0] i
  );
    logic [511:0] l;
    for (int w = 0; w < 16; w++)
      l[w*32 +: 32] = mem_word({t, i, 4'(w), 2'b00});
    return l;
  endfunction

  function automatic logic [511:0] vline(input logic [31:0] base);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  // memory responder: acks after 'delay' waiting cycles per beat
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && wait_cnt >= delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        wait_cnt      = 0;
      end else begin
        bus.mem_ack = stray_ack;
        if (bus.mem_req) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  // beat logger and stall-stability monitor
  initial begin
    logic        was_stall;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    was_stall = 1'b0;
    s_addr = '0; s_wdata = '0; s_we = 1'b0;
    forever begin
      @(posedge clk);
      if (was_stall && bus.mem_req &&
          (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
           bus.mem_we !== s_we))
        stab_err++;
      was_stall = rst && bus.mem_req && !bus.mem_ack;
      if (was_stall) begin
        stalls++;
        s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_we = bus.mem_we;
      end
      if (rst && bus.mem_req && bus.mem_ack) begin
        log_addr.push_back(bus.mem_addr);
        log_wdata.push_back(bus.mem_wdata);
        log_we.push_back(bus.mem_we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic issue_miss(
    input logic [31:0] a, input logic [3:0] v,
    input logic [3:0] d, input logic [3:0] l
  );
    @(negedge clk);
    bus.miss_addr  = a;
    bus.set_valid  = v;
    bus.set_dirty  = d;
    bus.set_lru    = l;
    bus.miss_valid = 1'b1;
    log_addr.delete();
    log_wdata.delete();
    log_we.delete();
    stalls   = 0;
    stab_err = 0;
    @(posedge clk);
    #1 bus.miss_valid = 1'b0;
  endtask

  task automatic wait_fill(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus.fill_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_miss_ready: got %b want 1", bus.miss_ready);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem: req %b we %b want 0 0",
                         bus.mem_req, bus.mem_we);
    end
    n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.victim_way !== 2'd0) begin
      n_fail++; $display("FAIL rst_addr_way: addr %h way %0d want 0 0",
                         bus.mem_addr, bus.victim_way);
    end
    n_checks++;
    if (bus.fill_valid !== 1'b0 || bus.fill_line !== '0) begin
      n_fail++; $display("FAIL rst_fill: valid %b line nonzero=%b want 0",
                         bus.fill_valid, |bus.fill_line);
    end
    rst = 1'b1;
  endtask

  task automatic test_clean_miss;
    int n;
    int nw;
    issue_miss(32'h0000_1234, 4'h0, 4'h0, 4'h0);
    wait_fill(n);
    n_checks++;
    if (n !== 18) begin
      n_fail++; $display("FAIL clean_latency: got %0d want 18", n);
    end
    n_checks++;
    if (bus.fill_way !== 2'd0 || bus.victim_way !== 2'd0) begin
      n_fail++; $display("FAIL clean_way: fill %0d victim %0d want 0",
                         bus.fill_way, bus.victim_way);
    end
    n_checks++;
    if (bus.fill_index !== 8'h48 || bus.fill_tag !== 18'h0) begin
      n_fail++; $display("FAIL clean_idx_tag: idx %h tag %h want 48 0",
                         bus.fill_index, bus.fill_tag);
    end
    n_checks++;
    if (bus.fill_line[13*32 +: 32] !== mem_word(32'h0000_1234)) begin
      n_fail++; $display("FAIL clean_crit_word: got %h want %h",
                         bus.fill_line[13*32 +: 32], mem_word(32'h1234));
    end
    n_checks++;
    if (bus.fill_line !== exp_line(18'h0, 8'h48)) begin
      n_fail++; $display("FAIL clean_line: got %h want %h",
                         bus.fill_line, exp_line(18'h0, 8'h48));
    end
    nw = 0;
    foreach (log_we[k]) if (log_we[k]) nw++;
    n_checks++;
    if (log_addr.size() !== 16 || nw !== 0) begin
      n_fail++; $display("FAIL clean_beats: got %0d beats %0d writes want 16 0",
                         log_addr.size(), nw);
    end
    n_checks++;
    if (log_addr.size() != 16 || log_addr[0] !== 32'h0000_1234 ||
        log_addr[3] !== 32'h0000_1200 || log_addr[15] !== 32'h0000_1230) begin
      n_fail++; $display("FAIL clean_order: beats %0d first/wrap/last wrong",
                         log_addr.size());
    end
    @(negedge clk);
    n_checks++;
    if (bus.fill_valid !== 1'b0 || bus.fill_index !== 8'h48 ||
        bus.miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL clean_pulse: valid %b idx %h ready %b want 0 48 1",
                         bus.fill_valid, bus.fill_index, bus.miss_ready);
    end
  endtask

  task automatic test_dirty_victim;
    int n;
    int err;
    bus.victim_tag  = 18'h3FFFF;
    bus.victim_line = vline(32'hD000_0000);
    issue_miss(32'h0004_5678, 4'hF, 4'b0100, 4'b1011);
    @(negedge clk);
    n_checks++;
    if (bus.victim_way !== 2'd2) begin
      n_fail++; $display("FAIL dirty_victim_way: got %0d want 2", bus.victim_way);
    end
    wait_fill(n);
    n_checks++;
    if (n + 1 !== 34) begin
      n_fail++; $display("FAIL dirty_latency: got %0d want 34", n + 1);
    end
    n_checks++;
    if (log_addr.size() !== 32) begin
      n_fail++; $display("FAIL dirty_beats: got %0d want 32", log_addr.size());
    end
    err = 0;
    if (log_addr.size() == 32) begin
      for (int w = 0; w < 16; w++)
        if (!log_we[w] || log_addr[w] !== 32'hFFFF_D640 + 32'(4*w) ||
            log_wdata[w] !== 32'hD000_0000 + 32'(w)) err++;
      for (int w = 16; w < 32; w++) if (log_we[w]) err++;
    end else err = 1;
    n_checks++;
    if (err !== 0) begin
      n_fail++; $display("FAIL dirty_wb_beats: got %0d bad beats want 0", err);
    end
    n_checks++;
    if (log_addr.size() != 32 || log_addr[16] !== 32'h0004_5678 ||
        log_addr[31] !== 32'h0004_5674) begin
      n_fail++; $display("FAIL dirty_read_order: first/last read address wrong");
    end
    n_checks++;
    if (bus.fill_way !== 2'd2 || bus.fill_tag !== 18'h11 ||
        bus.fill_index !== 8'h59) begin
      n_fail++; $display("FAIL dirty_fill_hdr: way %0d tag %h idx %h want 2 11 59",
                         bus.fill_way, bus.fill_tag, bus.fill_index);
    end
    n_checks++;
    if (bus.fill_line !== exp_line(18'h11, 8'h59)) begin
      n_fail++; $display("FAIL dirty_line: got %h want %h",
                         bus.fill_line, exp_line(18'h11, 8'h59));
    end
  endtask

  task automatic test_lru_all_set;
    int n;
    int nw;
    issue_miss(32'h00AB_CDC0, 4'hF, 4'b1110, 4'hF);
    @(negedge clk);
    n_checks++;
    if (bus.victim_way !== 2'd0) begin
      n_fail++; $display("FAIL lru_way: got %0d want 0", bus.victim_way);
    end
    wait_fill(n);
    n_checks++;
    if (n + 1 !== 18) begin
      n_fail++; $display("FAIL lru_latency: got %0d want 18", n + 1);
    end
    nw = 0;
    foreach (log_we[k]) if (log_we[k]) nw++;
    n_checks++;
    if (nw !== 0 || log_addr.size() !== 16) begin
      n_fail++; $display("FAIL lru_beats: writes %0d beats %0d want 0 16",
                         nw, log_addr.size());
    end
  endtask

  task automatic test_wait_states;
    int n;
    int err;
    delay = 3;
    bus.victim_tag  = 18'h2_0001;
    bus.victim_line = vline(32'hE000_0000);
    issue_miss(32'h0000_0ABC, 4'hF, 4'b0001, 4'b1110);
    wait_fill(n);
    n_checks++;
    if (n !== 130) begin
      n_fail++; $display("FAIL wait_latency: got %0d want 130", n);
    end
    n_checks++;
    if (log_addr.size() !== 32 || stalls !== 96) begin
      n_fail++; $display("FAIL wait_beats: beats %0d stalls %0d want 32 96",
                         log_addr.size(), stalls);
    end
    n_checks++;
    if (stab_err !== 0) begin
      n_fail++; $display("FAIL wait_stable: got %0d changes want 0", stab_err);
    end
    err = 0;
    if (log_addr.size() == 32) begin
      for (int w = 0; w < 16; w++)
        if (log_addr[w] !== {18'h2_0001, 8'h2A, 4'(w), 2'b00} ||
            log_wdata[w] !== 32'hE000_0000 + 32'(w)) err++;
    end else err = 1;
    n_checks++;
    if (err !== 0) begin
      n_fail++; $display("FAIL wait_wb_data: got %0d bad beats want 0", err);
    end
    n_checks++;
    if (bus.fill_line !== exp_line(18'h0, 8'h2A) || bus.fill_way !== 2'd0) begin
      n_fail++; $display("FAIL wait_line: way %0d line %h want 0 %h",
                         bus.fill_way, bus.fill_line, exp_line(18'h0, 8'h2A));
    end
    delay = 0;
  endtask

  task automatic test_reset_mid_wb;
    int n;
    bit hit;
    bus.victim_tag  = 18'h1_2345;
    bus.victim_line = vline(32'h7000_0000);
    issue_miss(32'h1234_5600, 4'hF, 4'b0100, 4'b1011);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we && bus.mem_addr[5:2] == 4'd7) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (hit !== 1'b1) begin
      n_fail++; $display("FAIL rstwb_reach_beat7: got %b want 1", hit);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstwb_abort: req %b busy %b ready %b want 0 0 1",
                         bus.mem_req, bus.busy, bus.miss_ready);
    end
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.fill_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstwb_stray_ack: req %b busy %b fill %b want 0",
                         bus.mem_req, bus.busy, bus.fill_valid);
    end
    issue_miss(32'h0000_0040, 4'h0, 4'h0, 4'h0);
    wait_fill(n);
    n_checks++;
    if (n !== 18 || bus.fill_line !== exp_line(18'h0, 8'h01)) begin
      n_fail++; $display("FAIL rstwb_recover: latency %0d want 18, line ok %b",
                         n, bus.fill_line === exp_line(18'h0, 8'h01));
    end
  endtask

  task automatic test_busy_ignore;
    int pulses;
    int first;
    logic rdy5;
    issue_miss(32'h0001_0000, 4'h0, 4'h0, 4'h0);
    pulses = 0;
    first  = -1;
    rdy5   = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.miss_addr  = 32'h0002_0040;
        bus.miss_valid = 1'b1;
      end
      if (i == 10) bus.miss_valid = 1'b0;
      if (i == 5) rdy5 = bus.miss_ready;
      if (bus.fill_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (rdy5 !== 1'b0) begin
      n_fail++; $display("FAIL busy_ready: got %b want 0", rdy5);
    end
    n_checks++;
    if (pulses !== 1 || first !== 18) begin
      n_fail++; $display("FAIL busy_pulses: got %0d at %0d want 1 at 18",
                         pulses, first);
    end
    n_checks++;
    if (bus.fill_tag !== 18'h4 || bus.fill_index !== 8'h0) begin
      n_fail++; $display("FAIL busy_tag: tag %h idx %h want 4 0",
                         bus.fill_tag, bus.fill_index);
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.miss_valid  = 1'b0;
    bus.miss_addr   = '0;
    bus.set_valid   = '0;
    bus.set_dirty   = '0;
    bus.set_lru     = '0;
    bus.victim_tag  = '0;
    bus.victim_line = '0;
    stalls          = 0;
    stab_err        = 0;
    test_reset();
    test_clean_miss();
    test_dirty_victim();
    test_lru_all_set();
    test_wait_states();
    test_reset_mid_wb();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
